// File: rtl/pin_entry_ctrl.sv
// Keypad PIN collector: BCD digit assembly, edit keys, inactivity abort, attempt lockout.
// All outputs registered, one cycle after the causing input; no backpressure (strobes are accepted or dropped).
module pin_entry_ctrl #(
  parameter int DIGITS         = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TO_W           = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              key_valid,
  input  logic [3:0]                        key_code,
  input  logic                              verify_done,
  input  logic                              verify_ok,
  input  logic                              unlock,
  output logic [4*DIGITS-1:0]               pin_out,
  output logic                              pin_load,
  output logic [$clog2(DIGITS+1)-1:0]       digit_cnt,
  output logic                              entry_active,
  output logic                              timeout,
  output logic                              granted,
  output logic                              locked,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts
);

  localparam int CW = $clog2(DIGITS+1);
  localparam int AW = $clog2(MAX_ATTEMPTS+1);

  localparam logic [3:0] KEY_BS  = 4'hA;
  localparam logic [3:0] KEY_CLR = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_WAIT_VERIFY,
    S_LOCKED
  } state_t;

  state_t           state;
  logic [TO_W-1:0]  timer;
  logic             key_acc;
  logic             key_digit;
  logic [4*DIGITS-1:0] pin_shift;

  // Reserved codes 0xD-0xF never count as activity.
  assign key_acc   = key_valid && (key_code <= 4'hC);
  assign key_digit = key_valid && (key_code <= 4'h9);
  assign pin_shift = {pin_out[4*DIGITS-5:0], key_code};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pin_out      <= '0;
      digit_cnt    <= '0;
      attempts     <= '0;
      timer        <= '0;
      pin_load     <= 1'b0;
      timeout      <= 1'b0;
      granted      <= 1'b0;
      entry_active <= 1'b0;
      locked       <= 1'b0;
    end else begin
      pin_load <= 1'b0;
      timeout  <= 1'b0;
      granted  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (key_digit) begin
            pin_out      <= pin_shift;
            digit_cnt    <= CW'(1);
            timer        <= '0;
            state        <= S_ENTRY;
            entry_active <= 1'b1;
          end
        end
        S_ENTRY: begin
          if (key_acc) begin
            timer <= '0;
            if (key_digit) begin
              if (digit_cnt != CW'(DIGITS)) begin
                pin_out   <= pin_shift;
                digit_cnt <= digit_cnt + CW'(1);
              end
            end else if (key_code == KEY_BS) begin
              pin_out   <= pin_out >> 4;
              digit_cnt <= digit_cnt - CW'(1);
              if (digit_cnt == CW'(1)) begin
                state        <= S_IDLE;
                entry_active <= 1'b0;
              end
            end else if (key_code == KEY_CLR) begin
              pin_out      <= '0;
              digit_cnt    <= '0;
              state        <= S_IDLE;
              entry_active <= 1'b0;
            end else if (digit_cnt == CW'(DIGITS)) begin
              // pin_out already holds the full PIN, so the latch captures it on this strobe.
              pin_load     <= 1'b1;
              state        <= S_WAIT_VERIFY;
              entry_active <= 1'b0;
            end
          end else if (timer == TO_W'(TIMEOUT_CYCLES-1)) begin
            timeout      <= 1'b1;
            pin_out      <= '0;
            digit_cnt    <= '0;
            timer        <= '0;
            state        <= S_IDLE;
            entry_active <= 1'b0;
          end else begin
            timer <= timer + TO_W'(1);
          end
        end
        S_WAIT_VERIFY: begin
          if (verify_done) begin
            pin_out   <= '0;
            digit_cnt <= '0;
            if (verify_ok) begin
              granted  <= 1'b1;
              attempts <= '0;
              state    <= S_IDLE;
            end else begin
              attempts <= attempts + AW'(1);
              if (attempts == AW'(MAX_ATTEMPTS-1)) begin
                state  <= S_LOCKED;
                locked <= 1'b1;
              end else begin
                state <= S_IDLE;
              end
            end
          end
        end
        S_LOCKED: begin
          if (unlock) begin
            attempts <= '0;
            locked   <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Bench for pin_entry_ctrl: directed scenarios plus randomized traffic against a digit-queue model.
module tb_pin_entry_ctrl;

  localparam int DIGITS = 4;
  localparam int TO     = 8;
  localparam int MAXA   = 3;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_WAIT = 2, M_LOCK = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        verify_done = 1'b0;
  logic        verify_ok = 1'b0;
  logic        unlock = 1'b0;
  logic [15:0] pin_out;
  logic        pin_load;
  logic [2:0]  digit_cnt;
  logic        entry_active;
  logic        timeout;
  logic        granted;
  logic        locked;
  logic [1:0]  attempts;

  int errors = 0;
  int checks = 0;

  // Reference model: held digits oldest-first, plus mode, idle count and attempts.
  int m_q[$];
  int m_mode = M_IDLE;
  int m_idle = 0;
  int m_att  = 0;
  bit m_load = 0, m_to = 0, m_gr = 0;

  logic [25:0] act_vec;
  assign act_vec = {pin_out, pin_load, digit_cnt, entry_active, timeout, granted, locked, attempts};

  pin_entry_ctrl #(.DIGITS(DIGITS), .TIMEOUT_CYCLES(TO), .MAX_ATTEMPTS(MAXA), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .verify_done(verify_done), .verify_ok(verify_ok), .unlock(unlock),
    .pin_out(pin_out), .pin_load(pin_load), .digit_cnt(digit_cnt),
    .entry_active(entry_active), .timeout(timeout), .granted(granted),
    .locked(locked), .attempts(attempts)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] exp_vec();
    logic [15:0] p = 16'h0;
    foreach (m_q[i]) p = (p << 4) | 16'(m_q[i]);
    return {p, m_load, 3'(m_q.size()), (m_mode == M_ENTRY), m_to, m_gr,
            (m_mode == M_LOCK), 2'(m_att)};
  endfunction

  task automatic model_update();
    bit acc;
    int k;
    k = int'(key_code);
    acc = key_valid && k <= 12;
    m_load = 0; m_to = 0; m_gr = 0;
    if (rst) begin
      m_q.delete(); m_mode = M_IDLE; m_idle = 0; m_att = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (acc && k <= 9) begin m_q = {k}; m_idle = 0; m_mode = M_ENTRY; end
      M_ENTRY: begin
        if (acc) begin
          m_idle = 0;
          if (k <= 9) begin
            if (m_q.size() < DIGITS) m_q.push_back(k);
          end else if (k == 10) begin
            void'(m_q.pop_back());
            if (m_q.size() == 0) m_mode = M_IDLE;
          end else if (k == 11) begin
            m_q.delete(); m_mode = M_IDLE;
          end else if (m_q.size() == DIGITS) begin
            m_load = 1; m_mode = M_WAIT;
          end
        end else begin
          m_idle++;
          if (m_idle == TO) begin m_to = 1; m_q.delete(); m_mode = M_IDLE; m_idle = 0; end
        end
      end
      M_WAIT: if (verify_done) begin
        m_q.delete();
        if (verify_ok) begin m_gr = 1; m_att = 0; m_mode = M_IDLE; end
        else begin m_att++; m_mode = (m_att == MAXA) ? M_LOCK : M_IDLE; end
      end
      default: if (unlock) begin m_att = 0; m_mode = M_IDLE; end
    endcase
  endtask

  // One clock with the given inputs; outputs are stable to sample when it returns.
  task automatic step(input bit kv, input logic [3:0] kc, input bit vd, input bit vo,
                      input bit ul, input bit r);
    key_valid = kv; key_code = kc; verify_done = vd; verify_ok = vo; unlock = ul; rst = r;
    @(posedge clk);
    model_update();
    #1;
    key_valid = 0; key_code = 0; verify_done = 0; verify_ok = 0; unlock = 0; rst = 0;
  endtask

  task automatic press(input logic [3:0] kc);
    step(1, kc, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'h0, 0, 0, 0, 0);
  endtask

  task automatic enter_pin(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) press(p[i*4 +: 4]);
    press(4'hC);
  endtask

  task automatic test_reset();
    step(0, 4'h0, 0, 0, 0, 1);
    step(0, 4'h0, 0, 0, 0, 1);
    checks++;
    if (act_vec !== 26'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", act_vec);
    end
  endtask

  task automatic test_basic_entry();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    checks++;
    if (pin_out !== 16'h1234 || digit_cnt !== 3'd4) begin
      errors++; $display("FAIL basic_pin: got pin=%h cnt=%0d expected pin=1234 cnt=4", pin_out, digit_cnt);
    end
    press(4'hC);
    checks++;
    if (pin_load !== 1'b1 || pin_out !== 16'h1234) begin
      errors++; $display("FAIL basic_load: got load=%b pin=%h expected load=1 pin=1234", pin_load, pin_out);
    end
    press(4'h5);
    checks++;
    if (pin_load !== 1'b0 || pin_out !== 16'h1234 || digit_cnt !== 3'd4 || entry_active !== 1'b0) begin
      errors++; $display("FAIL basic_wait_hold: got load=%b pin=%h cnt=%0d act=%b expected 0/1234/4/0",
                         pin_load, pin_out, digit_cnt, entry_active);
    end
    step(0, 4'h0, 1, 1, 0, 0);
    checks++;
    if (granted !== 1'b1 || pin_out !== 16'h0) begin
      errors++; $display("FAIL basic_grant: got granted=%b pin=%h expected 1/0000", granted, pin_out);
    end
  endtask

  task automatic test_edit_keys();
    press(4'h1); press(4'h2); press(4'hA); press(4'h7); press(4'h8); press(4'h9); press(4'hC);
    checks++;
    if (pin_load !== 1'b1 || pin_out !== 16'h1789) begin
      errors++; $display("FAIL edit_backspace: got load=%b pin=%h expected 1/1789", pin_load, pin_out);
    end
    step(0, 4'h0, 1, 1, 0, 0);
    press(4'h1); press(4'hB);
    checks++;
    if (pin_out !== 16'h0 || digit_cnt !== 3'd0 || entry_active !== 1'b0) begin
      errors++; $display("FAIL edit_clear: got pin=%h cnt=%0d act=%b expected 0/0/0", pin_out, digit_cnt, entry_active);
    end
    press(4'h1); press(4'h2); press(4'hC);
    checks++;
    if (pin_load !== 1'b0 || entry_active !== 1'b1 || digit_cnt !== 3'd2) begin
      errors++; $display("FAIL edit_short_enter: got load=%b act=%b cnt=%0d expected 0/1/2", pin_load, entry_active, digit_cnt);
    end
    press(4'hB);
  endtask

  task automatic test_timeout();
    press(4'h5);
    for (int i = 1; i < TO; i++) begin
      idle(1);
      checks++;
      if (timeout !== 1'b0 || entry_active !== 1'b1) begin
        errors++; $display("FAIL timeout_early: cycle %0d got to=%b act=%b expected 0/1", i, timeout, entry_active);
      end
    end
    idle(1);
    checks++;
    if (timeout !== 1'b1 || pin_out !== 16'h0 || entry_active !== 1'b0) begin
      errors++; $display("FAIL timeout_fire: got to=%b pin=%h act=%b expected 1/0000/0", timeout, pin_out, entry_active);
    end
    idle(1);
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse_width: got to=%b expected 0", timeout);
    end
    press(4'h5);
    idle(TO - 1);
    press(4'h6);
    checks++;
    if (timeout !== 1'b0 || digit_cnt !== 3'd2 || pin_out !== 16'h0056) begin
      errors++; $display("FAIL timeout_key_wins: got to=%b cnt=%0d pin=%h expected 0/2/0056", timeout, digit_cnt, pin_out);
    end
    press(4'hB);
  endtask

  task automatic test_lockout();
    for (int a = 1; a <= MAXA; a++) begin
      enter_pin(16'h1111);
      step(0, 4'h0, 1, 0, 0, 0);
      checks++;
      if (attempts !== 2'(a) || locked !== (a == MAXA)) begin
        errors++; $display("FAIL lock_attempts: got att=%0d locked=%b expected %0d/%b", attempts, locked, a, a == MAXA);
      end
    end
    press(4'h1); step(0, 4'h0, 1, 1, 0, 0);
    checks++;
    if (digit_cnt !== 3'd0 || entry_active !== 1'b0 || locked !== 1'b1 || granted !== 1'b0) begin
      errors++; $display("FAIL lock_ignores: got cnt=%0d act=%b locked=%b gr=%b expected 0/0/1/0",
                         digit_cnt, entry_active, locked, granted);
    end
    step(0, 4'h0, 0, 0, 1, 0);
    checks++;
    if (attempts !== 2'd0 || locked !== 1'b0) begin
      errors++; $display("FAIL lock_unlock: got att=%0d locked=%b expected 0/0", attempts, locked);
    end
  endtask

  task automatic test_grant_after_failures();
    for (int a = 0; a < 2; a++) begin enter_pin(16'h2468); step(0, 4'h0, 1, 0, 0, 0); end
    step(0, 4'h0, 0, 0, 1, 0);
    checks++;
    if (attempts !== 2'd2) begin
      errors++; $display("FAIL stray_unlock: got att=%0d expected 2", attempts);
    end
    enter_pin(16'h2468);
    step(0, 4'h0, 1, 1, 0, 0);
    checks++;
    if (granted !== 1'b1 || attempts !== 2'd0 || locked !== 1'b0) begin
      errors++; $display("FAIL grant_clears: got gr=%b att=%0d locked=%b expected 1/0/0", granted, attempts, locked);
    end
  endtask

  task automatic test_reset_mid();
    press(4'h3); press(4'h1); press(4'h4);
    checks++;
    if (digit_cnt !== 3'd3) begin
      errors++; $display("FAIL rst_mid_pre: got cnt=%0d expected 3", digit_cnt);
    end
    step(1, 4'h5, 0, 0, 0, 1);
    checks++;
    if (act_vec !== 26'h0) begin
      errors++; $display("FAIL rst_mid_entry: got %h expected 0", act_vec);
    end
    enter_pin(16'h9999); step(0, 4'h0, 1, 0, 0, 0);
    enter_pin(16'h9999);
    step(0, 4'h0, 1, 0, 0, 1);
    checks++;
    if (attempts !== 2'd0 || act_vec !== 26'h0) begin
      errors++; $display("FAIL rst_vs_verify: got att=%0d vec=%h expected 0/0", attempts, act_vec);
    end
  endtask

  task automatic test_random();
    int pct, r;
    bit kv, vd, vo, ul, rs;
    logic [3:0] kc;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) pct = (n % 1500 == 0) ? 60 : (n % 1000 == 0) ? 25 : 10;
      kv = ($urandom_range(99) < pct);
      r = $urandom_range(11);
      if (r <= 6) kc = 4'($urandom_range(9));
      else if (r <= 8) kc = 4'hC;
      else if (r == 9) kc = 4'hA;
      else if (r == 10) kc = (($urandom_range(3) == 0) ? 4'hB : 4'hC);
      else kc = 4'($urandom_range(15, 13));
      vd = (m_mode == M_WAIT) ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      vo = ($urandom_range(2) == 0);
      ul = (m_mode == M_LOCK) ? ($urandom_range(7) == 0) : ($urandom_range(15) == 0);
      rs = ($urandom_range(299) == 0);
      step(kv, kc, vd, vo, ul, rs);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL random_cycle %0d: got %h expected %h", n, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_edit_keys();
    test_timeout();
    test_lockout();
    test_grant_after_failures();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
